// File: rtl/tb4004_pkg.sv
// tb4004_pkg: shared opcode/operand constants, phase and word-state enums and
// the JCN condition helper for the TB4004 condition-code slice.
package tb4004_pkg;

  // First-word opcodes that matter to branch/flag logic
  localparam logic [3:0] OPR_JCN = 4'h1;
  localparam logic [3:0] OPR_FIM = 4'h2;
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_JMS = 4'h5;
  localparam logic [3:0] OPR_ISZ = 4'h7;
  localparam logic [3:0] OPR_CC  = 4'hF;

  // Operand values of the explicit carry ops under OPR_CC
  localparam logic [3:0] CLC = 4'h1;
  localparam logic [3:0] STC = 4'hA;
  localparam logic [3:0] CMC = 4'h3;
  localparam logic [3:0] TCC = 4'h7;

  // Machine-cycle phases of one instruction word
  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_e;

  // Which word of an instruction is being fetched
  typedef enum logic [0:0] {WORD1 = 1'b0, WORD2 = 1'b1} word_state_e;

  // JCN condition: cc[2] zero, cc[1] carry, cc[0] TEST low, cc[3] inverts
  function automatic logic jcn_cond(input logic [3:0] cc,
                                    input logic       zero,
                                    input logic       carry,
                                    input logic       test_n);
    logic c;
    c = (cc[2] & zero) | (cc[1] & carry) | (cc[0] & ~test_n);
    return cc[3] ? ~c : c;
  endfunction

endpackage

// File: rtl/cc_branch_unit_if.sv
// cc_branch_unit_if: instruction/ALU inputs and phase/flag/strobe outputs of
// the branch unit. master = surrounding datapath, slave = cc_branch_unit.
interface cc_branch_unit_if #(
  parameter int DATA_W  = 4,
  parameter int CYCLE_N = 8
);
  localparam int CW = $clog2(CYCLE_N);

  logic              cycleEn;
  logic [DATA_W-1:0] opr;
  logic [DATA_W-1:0] opa;
  logic              aluCarry;
  logic              aluZero;
  logic              aluFlagsValid;
  logic              testIn;
  logic [CW-1:0]     cycle;
  logic              secondWord;
  logic              carryFlag;
  logic              zeroFlag;
  logic              testSync;
  logic              jumpTaken;

  modport master (
    output cycleEn, opr, opa, aluCarry, aluZero, aluFlagsValid, testIn,
    input  cycle, secondWord, carryFlag, zeroFlag, testSync, jumpTaken
  );

  modport slave (
    input  cycleEn, opr, opa, aluCarry, aluZero, aluFlagsValid, testIn,
    output cycle, secondWord, carryFlag, zeroFlag, testSync, jumpTaken
  );
endinterface

// File: rtl/cc_test_sync.sv
// cc_test_sync: DEPTH-flop synchroniser for the TEST pin; runs every clock,
// independent of the phase enable, and clears to 0 on reset.
module cc_test_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  if (DEPTH == 1) begin : g_single
    // single capture flop
    always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= d_i;
    end
  end else begin : g_chain
    // shift chain, oldest sample at the top bit
    always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/cc_branch_unit.sv
// cc_branch_unit: machine-phase counter, one/two-word tracking, carry/zero
// flags, synchronised TEST and JCN/ISZ/JUN/JMS jump strobe.
// Build option: CC_TEST_SYNC_EN selects a TEST_SYNC-deep synchroniser on
// testIn; without it a single flop is used (on-chip synchronous TEST only).
module cc_branch_unit
  import tb4004_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int CYCLE_N   = 8,
  parameter int TEST_SYNC = 2
) (
  input  logic             clk,
  input  logic             rst,
  cc_branch_unit_if.slave  bus
);

  localparam int CW = $clog2(CYCLE_N);
  localparam logic [CW-1:0] PH_M2 = CW'(int'(M2));
  localparam logic [CW-1:0] PH_X3 = CW'(CYCLE_N - 1);

  localparam logic [DATA_W-1:0] K_JCN = DATA_W'(OPR_JCN);
  localparam logic [DATA_W-1:0] K_FIM = DATA_W'(OPR_FIM);
  localparam logic [DATA_W-1:0] K_JUN = DATA_W'(OPR_JUN);
  localparam logic [DATA_W-1:0] K_JMS = DATA_W'(OPR_JMS);
  localparam logic [DATA_W-1:0] K_ISZ = DATA_W'(OPR_ISZ);
  localparam logic [DATA_W-1:0] K_CC  = DATA_W'(OPR_CC);
  localparam logic [DATA_W-1:0] K_CLC = DATA_W'(CLC);
  localparam logic [DATA_W-1:0] K_STC = DATA_W'(STC);
  localparam logic [DATA_W-1:0] K_CMC = DATA_W'(CMC);
  localparam logic [DATA_W-1:0] K_TCC = DATA_W'(TCC);

`ifdef CC_TEST_SYNC_EN
  localparam int unsigned SYNC_DEPTH = TEST_SYNC;
`else
  // TEST_SYNC only sizes the chain when the full synchroniser is built
  localparam int unsigned SYNC_DEPTH = 1 + 0 * TEST_SYNC;
`endif

  logic [CW-1:0]     cycle_q, cycle_d;
  word_state_e       state_q, state_d;
  logic [DATA_W-1:0] opr_q, opa_q;
  logic              cond_q, cond_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              jump_q, jump_d;
  logic              test_sync;

  logic              at_x3;
  logic              latch_en;
  logic              two_word;
  logic              take_branch;

  cc_test_sync #(
    .DEPTH (SYNC_DEPTH)
  ) u_test_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.testIn),
    .q_o (test_sync)
  );

  // Decode of the latched first word: two-word class and branch outcome
  always_comb begin
    two_word    = (opr_q == K_JCN) || ((opr_q == K_FIM) && !opa_q[0]) ||
                  (opr_q == K_JUN) || (opr_q == K_JMS) || (opr_q == K_ISZ);
    take_branch = ((opr_q == K_JCN) && cond_q) ||
                  (opr_q == K_JUN) || (opr_q == K_JMS) ||
                  ((opr_q == K_ISZ) && !bus.aluZero);
  end

  // Phase counter, word state, JCN condition capture and jump strobe
  always_comb begin
    at_x3    = bus.cycleEn && (cycle_q == PH_X3);
    latch_en = bus.cycleEn && (cycle_q == PH_M2) && (state_q == WORD1);
    cycle_d  = cycle_q;
    state_d  = state_q;
    cond_d   = cond_q;
    jump_d   = 1'b0;
    if (bus.cycleEn) begin
      cycle_d = (cycle_q == PH_X3) ? '0 : cycle_q + CW'(1);
    end
    if (at_x3) begin
      if (state_q == WORD1) begin
        state_d = two_word ? WORD2 : WORD1;
        cond_d  = jcn_cond(opa_q[3:0], zero_q, carry_q, test_sync);
      end else begin
        state_d = WORD1;
        jump_d  = take_branch;
      end
    end
  end

  // Flag update at the first-word X3: explicit carry ops beat ALU writes
  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (at_x3 && (state_q == WORD1)) begin
      if ((opr_q == K_CC) && ((opa_q == K_CLC) || (opa_q == K_TCC))) begin
        carry_d = 1'b0;
      end else if ((opr_q == K_CC) && (opa_q == K_STC)) begin
        carry_d = 1'b1;
      end else if ((opr_q == K_CC) && (opa_q == K_CMC)) begin
        carry_d = ~carry_q;
      end else if (bus.aluFlagsValid) begin
        carry_d = bus.aluCarry;
        zero_d  = bus.aluZero;
      end
    end
  end

  // Sequencing state; the strobe register reloads every clock so it lasts one clk
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      state_q <= WORD1;
      cond_q  <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      state_q <= state_d;
      cond_q  <= cond_d;
      jump_q  <= jump_d;
    end
  end

  // Flags and first-word instruction latch
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      opr_q   <= '0;
      opa_q   <= '0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
      if (latch_en) begin
        opr_q <= bus.opr;
        opa_q <= bus.opa;
      end
    end
  end

  assign bus.cycle      = cycle_q;
  assign bus.secondWord = (state_q == WORD2);
  assign bus.carryFlag  = carry_q;
  assign bus.zeroFlag   = zero_q;
  assign bus.testSync   = test_sync;
  assign bus.jumpTaken  = jump_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// tb_cc_branch_unit: instruction-level reference model with random stalls,
// random filler on don't-care phases and random TEST activity.
module tb_cc_branch_unit;

  localparam int DATA_W    = 4;
  localparam int CYCLE_N   = 8;
  localparam int TEST_SYNC = 2;
`ifdef CC_TEST_SYNC_EN
  localparam int LAT = TEST_SYNC;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cc_branch_unit_if #(.DATA_W(DATA_W), .CYCLE_N(CYCLE_N)) bus ();

  cc_branch_unit #(
    .DATA_W    (DATA_W),
    .CYCLE_N   (CYCLE_N),
    .TEST_SYNC (TEST_SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // model state (expected DUT outputs after the most recent edge)
  int m_phase;
  bit m_second, m_carry, m_zero, m_jump;
  bit hist[$];          // testIn seen at each edge (0 while in reset)
  bit toggle_on;
  bit stalls_on;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit exp_ts();
    return hist[hist.size() - LAT];
  endfunction

  task automatic clk_step(input bit en);
    bus.cycleEn = en;
    @(posedge clk);
    if (rst) begin
      hist.push_back(1'b0);
      m_phase = 0; m_second = 0; m_carry = 0; m_zero = 0; m_jump = 0;
    end else begin
      hist.push_back(bus.testIn);
      if (en) m_phase = (m_phase + 1) % CYCLE_N;
    end
    if (hist.size() > 16) void'(hist.pop_front());
    #1;
    check_val("cycle",      bus.cycle,      m_phase);
    check_val("secondWord", bus.secondWord, m_second);
    check_val("carryFlag",  bus.carryFlag,  m_carry);
    check_val("zeroFlag",   bus.zeroFlag,   m_zero);
    check_val("testSync",   bus.testSync,   exp_ts());
    check_val("jumpTaken",  bus.jumpTaken,  m_jump);
    m_jump = 0;
  endtask

  task automatic scramble();
    bus.opr           = 4'($urandom);
    bus.opa           = 4'($urandom);
    bus.aluFlagsValid = 1'($urandom);
    bus.aluCarry      = 1'($urandom);
    bus.aluZero       = 1'($urandom);
    if (toggle_on && ($urandom_range(0, 5) == 0)) bus.testIn = ~bus.testIn;
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      clk_step(1'b0);
    end
  endtask

  function automatic int rnd_stall();
    if (!stalls_on) return 0;
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  // One instruction: word 1 (+ word 2 when two-word). abort_at >= 0 resets
  // in word 2 once that phase is reached. x3_stall >= 0 forces the stall
  // length before the first-word X3.
  task automatic do_instr(input logic [3:0] o, input logic [3:0] a,
                          input bit fv, input bit ac, input bit az, input bit az2,
                          input int x3_stall, input int abort_at);
    bit two, c, cond, take, nc, nz;
    two  = (o == 4'h1) || (o == 4'h2 && !a[0]) || (o == 4'h4) || (o == 4'h5) || (o == 4'h7);
    for (int ph = 0; ph < CYCLE_N; ph++) begin
      if (ph == CYCLE_N - 1) stall((x3_stall >= 0) ? x3_stall : rnd_stall());
      else                   stall(rnd_stall());
      scramble();
      if (ph == 4) begin bus.opr = o; bus.opa = a; end
      if (ph == CYCLE_N - 1) begin
        bus.aluFlagsValid = fv; bus.aluCarry = ac; bus.aluZero = az;
        c    = (a[2] & m_zero) | (a[1] & m_carry) | (a[0] & ~exp_ts());
        cond = a[3] ? ~c : c;
        nc = m_carry; nz = m_zero;
        if (o == 4'hF && (a == 4'h1 || a == 4'h7)) nc = 0;
        else if (o == 4'hF && a == 4'hA)           nc = 1;
        else if (o == 4'hF && a == 4'h3)           nc = ~m_carry;
        else if (fv) begin nc = ac; nz = az; end
        m_carry = nc; m_zero = nz; m_second = two;
      end
      clk_step(1'b1);
    end
    if (!two) return;
    take = (o == 4'h1) ? cond : (o == 4'h4 || o == 4'h5) ? 1'b1 : (o == 4'h7) ? ~az2 : 1'b0;
    for (int ph = 0; ph < CYCLE_N; ph++) begin
      if (ph == abort_at) begin
        rst = 1'b1;
        scramble();
        clk_step(1'b1);
        rst = 1'b0;
        return;
      end
      stall(rnd_stall());
      scramble();
      if (ph == CYCLE_N - 1) begin
        bus.aluZero = az2;
        m_second = 0;
        m_jump   = take;
      end
      clk_step(1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] o, a;
    bit fv;
    rst = 1'b1;
    bus.cycleEn = 1'b1; bus.opr = '0; bus.opa = '0;
    bus.aluCarry = 0; bus.aluZero = 0; bus.aluFlagsValid = 0; bus.testIn = 1'b1;
    m_phase = 0; m_second = 0; m_carry = 0; m_zero = 0; m_jump = 0;
    toggle_on = 0; stalls_on = 0;
    for (int i = 0; i < LAT; i++) hist.push_back(1'b0);

    // reset state
    clk_step(1'b1);
    clk_step(1'b1);
    rst = 1'b0;

    // NOPs: counter runs and wraps, no second word
    do_instr(4'h0, 4'h0, 0, 0, 0, 0, -1, -1);
    do_instr(4'h0, 4'h0, 0, 0, 0, 0, -1, -1);

    // STC, CMC, CLC (ALU carry write in CLC's X3 loses)
    do_instr(4'hF, 4'hA, 0, 0, 0, 0, -1, -1);
    do_instr(4'hF, 4'h3, 0, 0, 0, 0, -1, -1);
    do_instr(4'hF, 4'h1, 1, 1, 0, 0, -1, -1);

    // JCN on carry, taken and inverted
    do_instr(4'hF, 4'hA, 0, 0, 0, 0, -1, -1);
    do_instr(4'h1, 4'h2, 0, 0, 0, 0, -1, -1);
    do_instr(4'h1, 4'hA, 0, 0, 0, 0, -1, -1);

    // JCN on TEST: high (not taken), then low (taken once synchronised)
    do_instr(4'h0, 4'h0, 0, 0, 0, 0, -1, -1);
    do_instr(4'h1, 4'h1, 0, 0, 0, 0, -1, -1);
    bus.testIn = 1'b0;
    do_instr(4'h1, 4'h1, 0, 0, 0, 0, -1, -1);

    // ISZ both ways, FIM
    do_instr(4'h7, 4'h3, 0, 0, 0, 0, -1, -1);
    do_instr(4'h7, 4'h3, 0, 0, 0, 1, -1, -1);
    do_instr(4'h2, 4'h0, 0, 0, 0, 0, -1, -1);

    // reset at WORD2 phase 5 of a JUN, then recovery
    do_instr(4'h4, 4'h9, 0, 0, 0, 0, -1, 5);
    do_instr(4'h0, 4'h0, 0, 0, 0, 0, -1, -1);

    // cycleEn low for 3 clocks at X3 of a flag-writing word, then a JMS
    do_instr(4'h0, 4'h0, 1, 1, 1, 0, 3, -1);
    do_instr(4'h5, 4'h0, 0, 0, 0, 0, 3, -1);

    // random instructions with stalls and TEST activity
    toggle_on = 1; stalls_on = 1;
    for (int n = 0; n < 200; n++) begin
      o  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      a  = 4'($urandom);
      fv = (o != 4'h1) ? 1'($urandom) : 1'b0;
      do_instr(o, a, fv, 1'($urandom), 1'($urandom), 1'($urandom), -1,
               ($urandom_range(0, 40) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cc_branch_unit.md
# cc_branch_unit

Parametrised successor to the TB4004 condition-code logic. It owns the eight-phase machine-cycle counter (A1..X3), tracks one- and two-word instructions, and holds the carry/zero flags and a synchronised TEST input. It evaluates JCN/ISZ/JUN/JMS branch decisions and issues a one-cycle jump strobe to the program-counter stack. It sits between the instruction register and the ALU/PC blocks.

## Interface
- DATA_W, 4: width of opr/opa words.
- CYCLE_N, 8: machine phases per instruction word; X3 = CYCLE_N-1.
- TEST_SYNC, 2: synchroniser depth on testIn (≥2).
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cycleEn  in  1  phase-advance enable; all state frozen when low.
- opr  in  DATA_W  first-word opcode, valid at phase M2 (index 4).
- opa  in  DATA_W  first-word operand, valid at phase M2.
- aluCarry  in  1  ALU carry out.
- aluZero  in  1  ALU result-is-zero.
- aluFlagsValid  in  1  ALU requests a flag write this X3.
- testIn  in  1  asynchronous external TEST pin (active-low condition).
- cycle  out  $clog2(CYCLE_N)  current phase.
- secondWord  out  1  current word is the operand word of a two-word instruction.
- carryFlag  out  1  carry/link flag.
- zeroFlag  out  1  zero flag.
- testSync  out  1  synchronised testIn.
- jumpTaken  out  1  one-cycle strobe: load PC with branch target.

## Operation
- Phase counter: on cycleEn, cycle increments; CYCLE_N-1 wraps to 0.
- States: WORD1, WORD2. At X3 of WORD1 with cycleEn, go to WORD2 if the latched opr is 0x1 (JCN), 0x2 with opa[0]=0 (FIM), 0x4 (JUN), 0x5 (JMS) or 0x7 (ISZ); otherwise stay in WORD1. At X3 of WORD2 return to WORD1. secondWord = (state==WORD2).
- opr/opa are latched at M2 of WORD1 only; they are held through WORD2 and ignored there.
- JCN condition, evaluated at X3 of WORD1 from the current flags: c = (opa[2]&zeroFlag)|(opa[1]&carryFlag)|(opa[0]&~testSync); cond = opa[3] ? ~c : c. cond is latched for WORD2.
- At X3 of WORD2, jumpTaken=1 for one clock: JCN if the latched cond=1; JUN/JMS always; ISZ if aluZero=0 at that X3; FIM never.
- Flag writes occur only at X3 of WORD1 with cycleEn. Explicit CC ops take priority over aluFlagsValid: opr 0xF with opa 0x1 (CLC) sets carry=0; 0xA (STC) sets carry=1; 0x3 (CMC) inverts carry; 0x7 (TCC) sets carry=0. Otherwise, if aluFlagsValid, carry<=aluCarry and zero<=aluZero.
- JCN reads the pre-update flags of its own X3. No flag write happens in the same word, because opr 0x1 is not a CC op and the ALU does not assert aluFlagsValid for JCN.
- testSync: TEST_SYNC-flop synchroniser; it updates every clk regardless of cycleEn.

## Timing
- Reset values: cycle=0, state WORD1, secondWord=0, carryFlag=0, zeroFlag=0, testSync=0, synchroniser flops 0, jumpTaken=0, latched opr/opa/cond=0.
- Reset mid-instruction aborts it. The next clock starts at A1 of WORD1, and no jumpTaken is issued.
- Flag outputs are registered and visible the clock after the X3 edge.
- jumpTaken is registered, asserts the clock after the WORD2 X3 edge, and lasts exactly one clk even if cycleEn then stays low.
- testIn to testSync latency: TEST_SYNC clocks.
- cycleEn low at X3 causes no state change, flag write or strobe until cycleEn returns high.

## Configuration
- CC_TEST_SYNC_EN defined: testIn goes through TEST_SYNC flops as above.
- Not defined: a single flop, latency 1 clk, and TEST_SYNC is ignored. The design is only for TB builds where TEST is generated on-chip synchronously.

## Structure
- Shared package tb4004_pkg holds:
  - opcode constants: OPR_JCN, OPR_FIM, OPR_JUN, OPR_JMS, OPR_ISZ, OPR_CC;
  - CC opa constants: CLC, STC, CMC, TCC;
  - the phase enum A1..X3;
  - the word-state enum.
- One sub-module is natural: cc_test_sync, the parametrised synchroniser.

## Test plan
- Reset with cycleEn=1 → cycle counts 0..7 and wraps; secondWord stays 0 for opr=0x0 (NOP).
- STC (0xFA), then CMC (0xF3), then CLC (0xF1) → carryFlag 1, 0, 0 after the respective X3 edges. aluFlagsValid=1 with aluCarry=1 in the same X3 as CLC → carry stays 0.
- carry=1, JCN opa=0x2 → secondWord for the next 8 phases and jumpTaken=1 after the WORD2 X3. With opa=0xA → no strobe.
- testIn=0 held, JCN opa=0x1 → taken only once testSync=0, with TEST_SYNC-clock latency checked.
- ISZ with aluZero=0 at WORD2 X3 → jumpTaken=1. With aluZero=1 → jumpTaken=0. FIM (0x20) → WORD2 entered, no strobe.
- rst asserted at WORD2 phase 5 of a JUN → cycle=0, WORD1, jumpTaken never pulses. cycleEn held low at X3 for 3 clocks → state frozen.
